regfile_wb_arbiter: RTL and testbench

//   Shares the single register-file write port between the execute writeback (ex) and the AXI load-response writeback (mem).

---
 rtl/riscv_wb_pkg.sv | 21 ++
 rtl/wb_scoreboard.sv | 62 ++++++
 rtl/regfile_wb_arbiter.sv | 140 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_wb_pkg
// Description : Shared widths and the writeback request record used by the
//               register-file writeback arbiter and its scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_wb_pkg;

    localparam int XLEN       = 32;
    localparam int NREG       = 32;
    localparam int REG_ADDR_W = $clog2(NREG);

    // One writeback: destination register plus the value to store there.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/wb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : wb_scoreboard
// Description : Per-register busy bits for loads still in flight.
//               Ports:
//                 clk, reset            clock / synchronous active-high reset
//                 set_valid, set_rd     load issued: mark set_rd busy
//                 clr_valid, clr_rd     load data written back: clear clr_rd
//                 rs_a/rs_b/rs_c        registers to look up
//                 hit_a/hit_b/hit_c     busy bit of each looked-up register
//                 busy                  full busy vector
// Revision    : 1.0 - initial release
// ============================================================================
module wb_scoreboard #(
    parameter int NREG   = 32,
    parameter int ADDR_W = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              set_valid,
    input  logic [ADDR_W-1:0] set_rd,
    input  logic              clr_valid,
    input  logic [ADDR_W-1:0] clr_rd,
    input  logic [ADDR_W-1:0] rs_a,
    input  logic [ADDR_W-1:0] rs_b,
    input  logic [ADDR_W-1:0] rs_c,
    output logic              hit_a,
    output logic              hit_b,
    output logic              hit_c,
    output logic [NREG-1:0]   busy
);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_next;

    // Set is applied after clear so that a load issued in the same cycle the
    // previous load to that register retires leaves the register busy.
    // x0 is hard-wired and can never be waited on.
    for (genvar i = 0; i < NREG; i++) begin : g_bit
        if (i == 0) begin : g_zero
            assign w_next[i] = 1'b0;
        end else begin : g_live
            assign w_next[i] = (set_valid && (set_rd == ADDR_W'(i)))
                             | (r_busy[i] && !(clr_valid && (clr_rd == ADDR_W'(i))));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_next;
        end
    end

    assign hit_a = r_busy[rs_a];
    assign hit_b = r_busy[rs_b];
    assign hit_c = r_busy[rs_c];
    assign busy  = r_busy;

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Shares the register-file write port between the execute
//               writeback (ex) and the load-response writeback (mem), tracks
//               in-flight loads and stalls decode on RAW/WAW conflicts.
//               Ports:
//                 clk, reset                 clock / sync active-high reset
//                 ex_valid/ex_ready/ex_rd/ex_data       execute writeback
//                 mem_valid/mem_ready/mem_rd/mem_data   load writeback
//                 ld_issue_valid, ld_issue_rd           load issued to AXI
//                 rs1, rs2, dec_rd, hazard_stall        decode hazard check
//                 rf_w_en, rf_rd, rf_w_data             registered RF write
//                 sb_busy                               scoreboard state
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
    import riscv_wb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [XLEN-1:0]       ex_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [XLEN-1:0]       mem_data,
    input  logic                  ld_issue_valid,
    input  logic [REG_ADDR_W-1:0] ld_issue_rd,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic [REG_ADDR_W-1:0] dec_rd,
    output logic                  hazard_stall,
    output logic                  rf_w_en,
    output logic [REG_ADDR_W-1:0] rf_rd,
    output logic [XLEN-1:0]       rf_w_data,
    output logic [NREG-1:0]       sb_busy
);

    localparam int         c_CNT_W    = 4;
    localparam logic [3:0] c_MAX_WAIT = c_CNT_W'(MAX_WAIT);

    logic [c_CNT_W-1:0] r_wait_cnt;
    logic               r_w_en;
    wb_req_t            r_out;

    logic               w_force_ex;
    logic               w_ex_waw;
    logic               w_ex_hs;
    logic               w_mem_hs;
    logic               w_any_hs;
    wb_req_t            w_sel;
    logic               w_hit_rs1;
    logic               w_hit_rs2;
    logic               w_hit_rd;

    // ------------------------------------------------------------------
    // Load scoreboard
    // ------------------------------------------------------------------
    wb_scoreboard #(
        .NREG   (NREG),
        .ADDR_W (REG_ADDR_W)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .set_valid (ld_issue_valid),
        .set_rd    (ld_issue_rd),
        .clr_valid (w_mem_hs),
        .clr_rd    (mem_rd),
        .rs_a      (rs1),
        .rs_b      (rs2),
        .rs_c      (dec_rd),
        .hit_a     (w_hit_rs1),
        .hit_b     (w_hit_rs2),
        .hit_c     (w_hit_rd),
        .busy      (sb_busy)
    );

    assign hazard_stall = w_hit_rs1 | w_hit_rs2 | w_hit_rd;

    // ------------------------------------------------------------------
    // Arbitration: mem normally wins; ex is forced through once it has
    // lost MAX_WAIT times in a row. An ex write to a register with a load
    // still outstanding must wait for that load, otherwise the older load
    // data would overwrite the newer ex result.
    // ------------------------------------------------------------------
    assign w_force_ex = (r_wait_cnt == c_MAX_WAIT);
    assign w_ex_waw   = sb_busy[ex_rd] && (ex_rd != '0);

    assign ex_ready  = !reset && !w_ex_waw && (!mem_valid || w_force_ex);
    assign mem_ready = !reset && (!w_force_ex || !ex_valid || w_ex_waw);

    assign w_ex_hs  = ex_valid  && ex_ready;
    assign w_mem_hs = mem_valid && mem_ready;
    assign w_any_hs = w_ex_hs || w_mem_hs;

    // The ready equations never grant both, so ex_hs alone selects.
    assign w_sel = w_ex_hs ? wb_req_t'{rd: ex_rd,  data: ex_data}
                           : wb_req_t'{rd: mem_rd, data: mem_data};

    // ------------------------------------------------------------------
    // Starvation counter: counts consecutive cycles a pending ex request
    // lost to mem.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if (!ex_valid || w_ex_hs) begin
            r_wait_cnt <= '0;
        end else if (w_mem_hs && (r_wait_cnt != c_MAX_WAIT)) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registered write port. Writes to x0 are accepted upstream but never
    // reach the register file; address/data hold when no write is issued.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_w_en <= 1'b0;
            r_out  <= '0;
        end else begin
            r_w_en <= w_any_hs && (w_sel.rd != '0);
            if (w_any_hs && (w_sel.rd != '0)) begin
                r_out <= w_sel;
            end
        end
    end

    assign rf_w_en   = r_w_en;
    assign rf_rd     = r_out.rd;
    assign rf_w_data = r_out.data;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Self-checking bench for regfile_wb_arbiter: directed scenario
//               tasks followed by a randomized run against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam int XLEN     = 32;
    localparam int NREG     = 32;
    localparam int AW       = 5;
    localparam int MAX_WAIT = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            ex_valid = 1'b0;
    logic            ex_ready;
    logic [AW-1:0]   ex_rd = '0;
    logic [XLEN-1:0] ex_data = '0;
    logic            mem_valid = 1'b0;
    logic            mem_ready;
    logic [AW-1:0]   mem_rd = '0;
    logic [XLEN-1:0] mem_data = '0;
    logic            ld_issue_valid = 1'b0;
    logic [AW-1:0]   ld_issue_rd = '0;
    logic [AW-1:0]   rs1 = '0;
    logic [AW-1:0]   rs2 = '0;
    logic [AW-1:0]   dec_rd = '0;
    logic            hazard_stall;
    logic            rf_w_en;
    logic [AW-1:0]   rf_rd;
    logic [XLEN-1:0] rf_w_data;
    logic [NREG-1:0] sb_busy;

    int n_checks = 0;
    int n_errors = 0;

    // Register file as the consumer sees it: commits on the negedge.
    logic [XLEN-1:0] tb_rf [NREG];

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rf_w_en && rf_rd != '0) tb_rf[rf_rd] <= rf_w_data;
    end

    regfile_wb_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk            (clk),
        .reset          (reset),
        .ex_valid       (ex_valid),
        .ex_ready       (ex_ready),
        .ex_rd          (ex_rd),
        .ex_data        (ex_data),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_rd         (mem_rd),
        .mem_data       (mem_data),
        .ld_issue_valid (ld_issue_valid),
        .ld_issue_rd    (ld_issue_rd),
        .rs1            (rs1),
        .rs2            (rs2),
        .dec_rd         (dec_rd),
        .hazard_stall   (hazard_stall),
        .rf_w_en        (rf_w_en),
        .rf_rd          (rf_rd),
        .rf_w_data      (rf_w_data),
        .sb_busy        (sb_busy)
    );

    task automatic clear_inputs();
        ex_valid = 1'b0; ex_rd = '0; ex_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        ld_issue_valid = 1'b0; ld_issue_rd = '0;
        rs1 = '0; rs2 = '0; dec_rd = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        clear_inputs();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        ex_valid = 1'b1; ex_rd = 5'd3; ex_data = 32'h1111_1111;
        mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h2222_2222;
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd6;
        #1;
        n_checks++;
        if (ex_ready !== 1'b0 || mem_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ready: ex_ready=%b mem_ready=%b expected 0/0", ex_ready, mem_ready);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        n_checks++;
        if (rf_w_en !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_wen: got %b expected 0", rf_w_en);
        end
        n_checks++;
        if (sb_busy !== '0) begin
            n_errors++;
            $display("FAIL reset_sb: got %h expected 0", sb_busy);
        end
        n_checks++;
        if (rf_rd !== '0 || rf_w_data !== '0) begin
            n_errors++;
            $display("FAIL reset_addr_data: rd=%0d data=%h expected 0/0", rf_rd, rf_w_data);
        end
        @(negedge clk);
        clear_inputs();
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_single_ex();
        do_reset();
        ex_valid = 1'b1; ex_rd = 5'd5; ex_data = 32'hDEAD_BEEF;
        #1;
        n_checks++;
        if (ex_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL single_ex_ready: got %b expected 1", ex_ready);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (rf_w_en !== 1'b1 || rf_rd !== 5'd5 || rf_w_data !== 32'hDEAD_BEEF) begin
            n_errors++;
            $display("FAIL single_ex_write: wen=%b rd=%0d data=%h expected 1/5/deadbeef",
                     rf_w_en, rf_rd, rf_w_data);
        end
        @(negedge clk);
        ex_valid = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (rf_w_en !== 1'b0) begin
            n_errors++;
            $display("FAIL single_ex_idle: wen=%b expected 0", rf_w_en);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_contention();
        logic exp_ex;
        do_reset();
        ex_valid = 1'b1; ex_rd = 5'd3; ex_data = 32'hE000_0000;
        mem_valid = 1'b1; mem_rd = 5'd4;
        for (int i = 0; i < 10; i++) begin
            mem_data = 32'hA000_0000 + i;
            exp_ex = ((i % (MAX_WAIT + 1)) == MAX_WAIT);
            #1;
            n_checks++;
            if (ex_ready !== exp_ex || mem_ready !== !exp_ex) begin
                n_errors++;
                $display("FAIL contention_ready[%0d]: ex_ready=%b mem_ready=%b expected %b/%b",
                         i, ex_ready, mem_ready, exp_ex, !exp_ex);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (rf_w_en !== 1'b1 || rf_rd !== (exp_ex ? 5'd3 : 5'd4) ||
                rf_w_data !== (exp_ex ? ex_data : mem_data)) begin
                n_errors++;
                $display("FAIL contention_write[%0d]: wen=%b rd=%0d data=%h expected rd %0d",
                         i, rf_w_en, rf_rd, rf_w_data, exp_ex ? 3 : 4);
            end
            @(negedge clk);
            if (exp_ex) ex_data = ex_data + 1;
        end
        clear_inputs();
    endtask

    // ------------------------------------------------------------------
    task automatic test_load_raw();
        do_reset();
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd7;
        @(posedge clk);
        @(negedge clk);
        ld_issue_valid = 1'b0;
        rs1 = 5'd7; rs2 = 5'd1; dec_rd = 5'd2;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (hazard_stall !== 1'b1 || sb_busy[7] !== 1'b1) begin
                n_errors++;
                $display("FAIL raw_stall[%0d]: stall=%b busy7=%b expected 1/1", i, hazard_stall, sb_busy[7]);
            end
            @(negedge clk);
        end
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h0000_1234;
        #1;
        n_checks++;
        if (mem_ready !== 1'b1 || hazard_stall !== 1'b1) begin
            n_errors++;
            $display("FAIL raw_hs: mem_ready=%b stall=%b expected 1/1", mem_ready, hazard_stall);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (hazard_stall !== 1'b0 || sb_busy[7] !== 1'b0) begin
            n_errors++;
            $display("FAIL raw_release: stall=%b busy7=%b expected 0/0", hazard_stall, sb_busy[7]);
        end
        n_checks++;
        if (rf_w_en !== 1'b1 || rf_rd !== 5'd7 || rf_w_data !== 32'h0000_1234) begin
            n_errors++;
            $display("FAIL raw_write: wen=%b rd=%0d data=%h expected 1/7/1234", rf_w_en, rf_rd, rf_w_data);
        end
        @(negedge clk);
        mem_valid = 1'b0;
        #1;
        n_checks++;
        if (tb_rf[7] !== 32'h0000_1234) begin
            n_errors++;
            $display("FAIL raw_rf_x7: got %h expected 00001234", tb_rf[7]);
        end
        clear_inputs();
    endtask

    // ------------------------------------------------------------------
    task automatic test_waw_setclr();
        do_reset();
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd9;
        @(posedge clk);
        @(negedge clk);
        ld_issue_valid = 1'b0;
        ex_valid = 1'b1; ex_rd = 5'd9; ex_data = 32'h0BAD_F00D;
        #1;
        n_checks++;
        if (ex_ready !== 1'b0 || mem_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL waw_block: ex_ready=%b mem_ready=%b expected 0/1", ex_ready, mem_ready);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (rf_w_en !== 1'b0) begin
            n_errors++;
            $display("FAIL waw_nowrite: wen=%b expected 0", rf_w_en);
        end
        @(negedge clk);
        mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h9999_0000;
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd9;
        #1;
        n_checks++;
        if (mem_ready !== 1'b1 || ex_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL waw_mem_ready: mem_ready=%b ex_ready=%b expected 1/0", mem_ready, ex_ready);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (sb_busy[9] !== 1'b1) begin
            n_errors++;
            $display("FAIL setclr_busy9: got %b expected 1", sb_busy[9]);
        end
        n_checks++;
        if (rf_w_en !== 1'b1 || rf_rd !== 5'd9 || rf_w_data !== 32'h9999_0000) begin
            n_errors++;
            $display("FAIL setclr_write: wen=%b rd=%0d data=%h expected 1/9/99990000", rf_w_en, rf_rd, rf_w_data);
        end
        @(negedge clk);
        mem_valid = 1'b0; ld_issue_valid = 1'b0;
        #1;
        n_checks++;
        if (ex_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL waw_still_blocked: ex_ready=%b expected 0", ex_ready);
        end
        clear_inputs();
    endtask

    // ------------------------------------------------------------------
    task automatic test_rd0_reset();
        do_reset();
        ex_valid = 1'b1; ex_rd = 5'd0; ex_data = 32'h5555_AAAA;
        #1;
        n_checks++;
        if (ex_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL rd0_ready: got %b expected 1", ex_ready);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (rf_w_en !== 1'b0) begin
            n_errors++;
            $display("FAIL rd0_nowrite: wen=%b expected 0", rf_w_en);
        end
        @(negedge clk);
        ex_valid = 1'b0;
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd13;
        @(posedge clk);
        @(negedge clk);
        ld_issue_valid = 1'b0;
        ex_valid = 1'b1; ex_rd = 5'd12; ex_data = 32'h1212_1212;
        reset = 1'b1;
        #1;
        n_checks++;
        if (ex_ready !== 1'b0 || mem_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_ready: ex_ready=%b mem_ready=%b expected 0/0", ex_ready, mem_ready);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (rf_w_en !== 1'b0 || sb_busy !== '0) begin
            n_errors++;
            $display("FAIL midreset_state: wen=%b sb=%h expected 0/0", rf_w_en, sb_busy);
        end
        @(negedge clk);
        reset = 1'b0;
        clear_inputs();
    endtask

    // ------------------------------------------------------------------
    // Randomized traffic against a behavioural model: busy set as an array,
    // a count of consecutive losses, and the winner chosen from the rules.
    // ------------------------------------------------------------------
    task automatic test_random();
        bit              m_busy [NREG];
        int              m_lost;
        bit              ex_pend, mem_pend, waw, starving;
        bit              exp_ex_rdy, exp_mem_rdy, exp_stall, ex_win, mem_win, exp_wen;
        logic [NREG-1:0] exp_sb;
        logic [AW-1:0]   exp_rd;
        logic [XLEN-1:0] exp_data;
        int              pick;
        do_reset();
        for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
        m_lost = 0; ex_pend = 0; mem_pend = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!ex_pend && ($urandom_range(1, 0) == 1)) begin
                ex_pend = 1; ex_rd = AW'($urandom_range(NREG - 1, 0)); ex_data = $urandom;
            end
            if (!mem_pend && ($urandom_range(2, 0) != 0)) begin
                mem_pend = 1;
                pick = $urandom_range(NREG - 1, 1);
                mem_rd = AW'($urandom_range(NREG - 1, 0));
                for (int k = 0; k < NREG; k++) begin
                    if (m_busy[(pick + k) % NREG]) begin
                        mem_rd = AW'((pick + k) % NREG);
                        break;
                    end
                end
                mem_data = $urandom;
            end
            ex_valid = ex_pend;
            mem_valid = mem_pend;
            ld_issue_valid = ($urandom_range(3, 0) == 0);
            ld_issue_rd = AW'($urandom_range(NREG - 1, 0));
            rs1 = AW'($urandom_range(NREG - 1, 0));
            rs2 = AW'($urandom_range(NREG - 1, 0));
            dec_rd = AW'($urandom_range(NREG - 1, 0));

            waw = (ex_rd != 0) && m_busy[ex_rd];
            starving = (m_lost == MAX_WAIT);
            exp_ex_rdy = !waw && (!mem_valid || starving);
            exp_mem_rdy = !(starving && ex_valid && !waw);
            exp_stall = m_busy[rs1] || m_busy[rs2] || m_busy[dec_rd];
            for (int r = 0; r < NREG; r++) exp_sb[r] = m_busy[r];
            #1;
            n_checks++;
            if (ex_ready !== exp_ex_rdy || mem_ready !== exp_mem_rdy) begin
                n_errors++;
                $display("FAIL rand_ready[%0d]: ex_ready=%b mem_ready=%b expected %b/%b",
                         cyc, ex_ready, mem_ready, exp_ex_rdy, exp_mem_rdy);
            end
            n_checks++;
            if (hazard_stall !== exp_stall || sb_busy !== exp_sb) begin
                n_errors++;
                $display("FAIL rand_sb[%0d]: stall=%b sb=%h expected %b/%h",
                         cyc, hazard_stall, sb_busy, exp_stall, exp_sb);
            end

            ex_win  = ex_valid && exp_ex_rdy;
            mem_win = mem_valid && exp_mem_rdy;
            exp_rd   = ex_win ? ex_rd : mem_rd;
            exp_data = ex_win ? ex_data : mem_data;
            exp_wen  = (ex_win || mem_win) && (exp_rd != 0);
            if (mem_win) m_busy[mem_rd] = 1'b0;
            if (ld_issue_valid) m_busy[ld_issue_rd] = 1'b1;
            m_busy[0] = 1'b0;
            if (!ex_valid || ex_win) m_lost = 0;
            else if (mem_win && m_lost < MAX_WAIT) m_lost++;
            if (ex_win) ex_pend = 0;
            if (mem_win) mem_pend = 0;

            @(posedge clk);
            #1;
            n_checks++;
            if (rf_w_en !== exp_wen || (exp_wen && (rf_rd !== exp_rd || rf_w_data !== exp_data))) begin
                n_errors++;
                $display("FAIL rand_write[%0d]: wen=%b rd=%0d data=%h expected %b/%0d/%h",
                         cyc, rf_w_en, rf_rd, rf_w_data, exp_wen, exp_rd, exp_data);
            end
            @(negedge clk);
        end
        clear_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int r = 0; r < NREG; r++) tb_rf[r] = '0;
        test_reset();
        test_single_ex();
        test_contention();
        test_load_raw();
        test_waw_setclr();
        test_rd0_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
